// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ controller.
package subleq_pkg;
    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] HALT_ADDR = 8'hFF;
    localparam int INSTR_CYCLES = 7;

    typedef enum logic [3:0] {
        IDLE, IA, IB, IC, RA, RB, LD, WB, HALT
    } state_t;
endpackage

// File: rtl/subtract8.sv
// Two's-complement subtractor; valid drops on signed overflow.
module subtract8
    import subleq_pkg::*;
(
    input  logic [WORD_W-1:0] minuend,
    input  logic [WORD_W-1:0] subtrahend,
    output logic [WORD_W-1:0] difference,
    output logic              valid
);
    assign difference = minuend - subtrahend;
    // Overflow only when operand signs differ and the result sign leaves the minuend's.
    assign valid = !((minuend[WORD_W-1] != subtrahend[WORD_W-1]) &&
                     (difference[WORD_W-1] != minuend[WORD_W-1]));
endmodule

// File: rtl/subleq_ctrl.sv
// Multi-cycle SUBLEQ sequencer driving a synchronous-read single-port memory.
module subleq_ctrl
    import subleq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [WORD_W-1:0] pc,
    output logic              instr_done,
    output logic              halted,
    output logic              ovf_err
);
    state_t            state;
    logic [WORD_W-1:0] reg_a, reg_b, reg_c, op_a, op_b;
    logic [WORD_W-1:0] diff;
    logic              diff_ok;
    logic              taken;
    logic              wb_commit;
    logic [WORD_W-1:0] next_pc;

    subtract8 u_sub (
        .minuend    (op_b),
        .subtrahend (op_a),
        .difference (diff),
        .valid      (diff_ok)
    );

    assign taken     = (diff == '0) || diff[WORD_W-1];
    assign next_pc   = taken ? reg_c : pc + 8'd3;
    // op_b only lands at the end of LD, so the write strobes are decoded from WB directly.
    assign wb_commit = (state == WB) && diff_ok;
    assign mem_we    = wb_commit;
    assign instr_done = wb_commit;
    assign mem_wdata = wb_commit ? diff : '0;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            reg_c    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            mem_addr <= '0;
            halted   <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc       <= '0;
                        ovf_err  <= 1'b0;
                        halted   <= 1'b0;
                        mem_addr <= '0;
                        state    <= IA;
                    end
                end
                IA: begin
                    mem_addr <= pc + 8'd1;
                    state    <= IB;
                end
                IB: begin
                    reg_a    <= mem_rdata;
                    mem_addr <= pc + 8'd2;
                    state    <= IC;
                end
                IC: begin
                    reg_b    <= mem_rdata;
                    mem_addr <= reg_a;
                    state    <= RA;
                end
                RA: begin
                    reg_c    <= mem_rdata;
                    mem_addr <= reg_b;
                    state    <= RB;
                end
                RB: begin
                    op_a  <= mem_rdata;
                    state <= LD;
                end
                LD: begin
                    op_b  <= mem_rdata;
                    state <= WB;
                end
                WB: begin
                    if (!diff_ok) begin
                        ovf_err <= 1'b1;
                        halted  <= 1'b1;
                        state   <= HALT;
                    end else begin
                        pc <= next_pc;
                        if (taken && (reg_c == HALT_ADDR)) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            mem_addr <= next_pc;
                            state    <= IA;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
